// File: rtl/multicycle_control32_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// primary opcode constants and the jr function code.
package multicycle_control32_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;

  // I-format arithmetic/logic ops share op[5:3] == 001
  localparam logic [2:0] OP_IFMT_HI = 3'b001;

endpackage

// File: rtl/multicycle_control32_decode.sv
// decode_ctrl32: purely combinational decode of the latched instruction
// fields into execute/register-file level controls and the instruction
// class flags the sequencer needs.
//   op_i, funct_i        latched instruction[31:26] / instruction[5:0]
//   ALUOp_o .. MemtoReg_o level controls, held for the whole instruction
//   lw_o .. illegal_o    class flags used by the sequencer
module decode_ctrl32
  import multicycle_control32_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [1:0] ALUOp_o,
  output logic       ALUSrc_o,
  output logic       I_format_o,
  output logic       Sftmd_o,
  output logic       Jr_o,
  output logic       RegDST_o,
  output logic       MemtoReg_o,
  output logic       lw_o,
  output logic       sw_o,
  output logic       beq_o,
  output logic       bne_o,
  output logic       j_o,
  output logic       jal_o,
  output logic       illegal_o
);

  logic r_fmt;
  logic i_fmt;

  assign r_fmt  = (op_i == OP_R);
  assign i_fmt  = (op_i[5:3] == OP_IFMT_HI);
  assign lw_o   = (op_i == OP_LW);
  assign sw_o   = (op_i == OP_SW);
  assign beq_o  = (op_i == OP_BEQ);
  assign bne_o  = (op_i == OP_BNE);
  assign j_o    = (op_i == OP_J);
  assign jal_o  = (op_i == OP_JAL);

  assign illegal_o = ~(r_fmt | i_fmt | lw_o | sw_o | beq_o | bne_o | j_o | jal_o);

  assign ALUOp_o    = {r_fmt | i_fmt, beq_o | bne_o};
  assign ALUSrc_o   = i_fmt | lw_o | sw_o;
  assign I_format_o = i_fmt;
  assign Sftmd_o    = r_fmt & (funct_i[5:3] == 3'b000);
  assign Jr_o       = r_fmt & (funct_i == FN_JR);
  assign RegDST_o   = r_fmt;
  assign MemtoReg_o = lw_o;

endmodule

// File: rtl/multicycle_control32.sv
// multicycle_control32: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Latches Opcode/Function_opcode when the instruction fetch completes and
// drives level controls (via decode_ctrl32) plus state-gated strobes.
//   clock, reset            rising-edge clock, synchronous active-high reset
//   Opcode, Function_opcode instruction fields, sampled on IR latch only
//   Zero, Mem_ready         ALU zero flag, memory access-complete handshake
//   ALUOp .. MemtoReg       level controls from the latched fields
//   RegWrite .. Illegal     per-cycle strobes
//   State                   current FSM state (debug)
module multicycle_control32
  import multicycle_control32_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  input  logic       Zero,
  input  logic       Mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       I_format,
  output logic       Sftmd,
  output logic       Jr,
  output logic       RegDST,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IR_write,
  output logic       PC_inc,
  output logic       PC_load,
  output logic       Illegal,
  output logic [2:0] State
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic [5:0] fn_q;

  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_illegal;

  decode_ctrl32 u_decode (
    .op_i       (op_q),
    .funct_i    (fn_q),
    .ALUOp_o    (ALUOp),
    .ALUSrc_o   (ALUSrc),
    .I_format_o (I_format),
    .Sftmd_o    (Sftmd),
    .Jr_o       (Jr),
    .RegDST_o   (RegDST),
    .MemtoReg_o (MemtoReg),
    .lw_o       (is_lw),
    .sw_o       (is_sw),
    .beq_o      (is_beq),
    .bne_o      (is_bne),
    .j_o        (is_j),
    .jal_o      (is_jal),
    .illegal_o  (is_illegal)
  );

  // Strobes depend on Mem_ready/Zero in the same cycle, so they are decoded
  // from the current state rather than registered; reset masks them all.
  always_comb begin
    state_d  = FETCH;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IR_write = 1'b0;
    PC_inc   = 1'b0;
    PC_load  = 1'b0;
    Illegal  = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        if (Mem_ready) begin
          IR_write = 1'b1;
          PC_inc   = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        if (is_j) begin
          PC_load = 1'b1;
          state_d = FETCH;
        end else if (is_jal) begin
          PC_load = 1'b1;
          state_d = WB;
        end else if (is_illegal) begin
          Illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_lw || is_sw) begin
          state_d = MEM;
        end else if (Jr) begin
          PC_load = 1'b1;
          state_d = FETCH;
        end else if (is_beq || is_bne) begin
          PC_load = (is_beq & Zero) | (is_bne & ~Zero);
          state_d = FETCH;
        end else begin
          // remaining classes here are R (non-jr) and I-format
          state_d = WB;
        end
      end
      MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (Mem_ready) begin
          state_d = is_lw ? WB : FETCH;
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (reset) begin
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IR_write = 1'b0;
      PC_inc   = 1'b0;
      PC_load  = 1'b0;
      Illegal  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && Mem_ready) begin
        op_q <= Opcode;
        fn_q <= Function_opcode;
      end
    end
  end

  assign State = state_q;

endmodule

// File: doc/multicycle_control32.md
MULTICYCLE_CONTROL32 -- requirements
Module: multicycle_control32

Interface
REQ-001 SHALL have one clock, `clock`; reset is synchronous and active-high, named `reset`.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 Opcode  input  6  instruction[31:26] from the memory read bus; sampled only on IR latch.
REQ-005 Function_opcode  input  6  instruction[5:0]; sampled with Opcode.
REQ-006 Zero  input  1  ALU zero flag from the execute unit.
REQ-007 Mem_ready  input  1  memory handshake; the current access completes in any cycle where it is 1.
REQ-008 ALUOp  output  2  {R_format|I_format, Branch|nBranch}.
REQ-009 ALUSrc, I_format, Sftmd, Jr  output  1 each  execute-unit controls, with the same meanings as on the execute unit.
REQ-010 RegDST, MemtoReg  output  1 each  register-file write-address and write-data selects.
REQ-011 RegWrite, MemRead, MemWrite, IR_write  output  1 each  state-gated strobes.
REQ-012 PC_inc, PC_load  output  1 each  one-cycle PC update strobes: PC+4 or target.
REQ-013 Illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-014 State  output  3  current FSM state, for debug.

Function
REQ-015 FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; other encodings SHALL go to FETCH.
REQ-016 FETCH: MemRead=1; hold while Mem_ready=0; when Mem_ready=1, pulse IR_write and PC_inc, latch Opcode/Function_opcode, then go to DECODE.
REQ-017 Decode groups, from latched fields:
- R = op 000000.
- I_format = op[5:3]==001.
- lw = 100011; sw = 101011.
- beq = 000100; bne = 000101.
- j = 000010; jal = 000011.
- Anything else is illegal.
REQ-018 Level controls SHALL be combinational from the latched fields and stable from DECODE to the end of the instruction:
- Sftmd = R & funct[5:3]==000.
- Jr = R & funct==001000.
- ALUSrc = I_format|lw|sw.
- RegDST = R.
- MemtoReg = lw.
REQ-019 Transitions out of DECODE:
- j -> FETCH, with a PC_load pulse.
- jal -> WB, with a PC_load pulse in DECODE.
- illegal -> FETCH, with an Illegal pulse.
- all others -> EXEC.
REQ-020 Transitions out of EXEC:
- lw/sw -> MEM.
- R (non-jr) and I_format -> WB.
- jr -> FETCH, with a PC_load pulse.
- beq/bne -> FETCH, with PC_load = (beq&Zero)|(bne&~Zero).
REQ-021 MEM: MemRead=lw, MemWrite=sw, held while Mem_ready=0; on Mem_ready=1, lw -> WB and sw -> FETCH.
REQ-022 WB: RegWrite=1 for exactly one cycle, then -> FETCH.
REQ-023 Strobes SHALL be asserted only in the states named above, and never otherwise.
REQ-024 Latency in cycles, with Mem_ready always 1:
- R/I: 4.
- lw: 5.
- sw: 4.
- beq/bne/jr: 3.
- j: 2.
- jal: 3.
REQ-025 PC_inc and PC_load SHALL never be asserted in the same cycle.

Reset
REQ-026 With reset=1 at a clock edge, State SHALL be FETCH and the latched fields SHALL be 0 on the next cycle.
REQ-027 While reset=1, all strobes SHALL be 0, including MemRead.
REQ-028 Reset asserted mid-instruction (any state, including a MEM wait) SHALL abort the instruction with no further strobes.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the opcode constants (R, lw, sw, beq, bne, j, jal) and the jr funct constant.
REQ-030 Level-control decode SHALL be one combinational sub-module, decode_ctrl32.
REQ-031 The sequencer and strobe gating SHALL stay in multicycle_control32.

Verification
REQ-032 add (op 000000, funct 100000), Mem_ready=1 -> states 0,1,2,4; RegWrite in cycle 4; RegDST=1; ALUOp=10.
REQ-033 lw (100011), Mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles with MemRead=1; WB follows with RegWrite=1 and MemtoReg=1; 7 cycles total.
REQ-034 beq with Zero=1 -> PC_load=1 in EXEC, ALUOp=01; beq with Zero=0 -> PC_load=0, back to FETCH after EXEC.
REQ-035 jal (000011) -> PC_load in DECODE, RegWrite in WB, 3 cycles; j -> 2 cycles, no RegWrite.
REQ-036 Opcode 111111 -> Illegal pulse in DECODE, return to FETCH, no RegWrite/MemWrite.
REQ-037 sw with reset asserted during the MEM wait -> next cycle State=0, MemWrite=0, no RegWrite.
